rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the SOC decoder.
- Owns the program counter and issues word requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents them to decode over a valid/ready handshake, each tagged with its PC.
- Accepts redirects (jump/branch/trap target) from downstream, which flush all queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
DEPTH, 4, FIFO entries and maximum outstanding requests (power of 2, 2..16).
CW, $clog2(DEPTH)+1, internal occupancy/credit counter width (derived, not overridden).

Ports:
CLK  in  1  clock, all logic on rising edge.
RESET  in  1  synchronous active-high reset.
imem_req  out  1  request strobe; memory always accepts in the same cycle.
imem_addr  out  32  byte address of the request, always word aligned.
imem_rvalid  in  1  response strobe; responses return in order, latency >=1 cycle.
imem_rdata  in  32  response instruction word.
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
redirect_pc  in  32  new fetch byte address.
instr_valid  out  1  instr/instr_pc hold a valid entry.
instr_ready  in  1  decode accepts the entry when high with instr_valid.
instr  out  32  instruction word at FIFO head.
instr_pc  out  32  byte address of instr.
fetch_fault  out  1  misaligned redirect fault (see Optional Feature).

Behaviour:
- Reset (RESET high at a clock edge):
  - pc=RESET_PC; FIFO empty; inflight=0; discard=0.
  - Outputs: imem_req=0, instr_valid=0, fetch_fault=0, instr/instr_pc=0.
  - Reset mid-operation drops everything. Responses arriving after reset from pre-reset requests are the memory's concern; the memory shares RESET.
- Issue:
  - imem_req is combinational: high when !RESET && !redirect_valid && !halted && (inflight + count) < DEPTH.
  - imem_addr=pc. On issue, pc += 4 (mod 2^32, wraps silently) and inflight += 1.
- Response:
  - On imem_rvalid, inflight -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise push {imem_rdata, tag_pc} into the FIFO. tag_pc is a per-entry PC queue written at issue time, so instr_pc always matches the word.
- Output:
  - instr_valid = (count != 0). instr/instr_pc come from the registered FIFO head.
  - Pop when instr_valid && instr_ready.
  - Minimum latency: req at cycle t, rvalid at t+L, instr_valid at t+L+1. There is no bypass path.
- Simultaneous push and pop in the same cycle keeps count unchanged. The credit rule guarantees the FIFO never overflows; an overflow is a design bug (assertion).
- Redirect (priority over everything else):
  - pc <= redirect_pc; FIFO flushed (count=0).
  - discard <= inflight_next, i.e. in-flight requests including any rvalid arriving in this same cycle, which is dropped.
  - No request is issued in the redirect cycle; the first new request issues the following cycle.
  - A pop handshake in the redirect cycle completes normally (decode consumed it), then the flush applies.
  - Back-to-back redirects: the latest one wins; discard is recomputed each time.
  - While discard>0, new requests are still issued. Their responses are accepted only after the discard count drains, which in-order return guarantees.
- Empty/full:
  - instr_ready while empty has no effect.
  - When inflight + count = DEPTH, issue stalls until a pop frees a credit; the request reissues in the cycle after the pop.
- Counters: inflight, count and discard are CW bits wide and never exceed DEPTH.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect with redirect_pc[1:0] != 0 flushes as normal, then sets halted=1 and fetch_fault=1, with the offending address latched internally.
  - No requests are issued while halted; in-flight responses are still discarded.
  - Cleared only by RESET or by a subsequent aligned redirect, which resumes fetch from that address.
- Undefined: redirect_pc[1:0] is forced to 00; fetch_fault is tied 0 and halted is constant 0.

Test Plan:
1. Reset release, memory latency 1, instr_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; first instr_valid 2 cycles after release with instr_pc=0x0.
2. instr_ready=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req=0. Raise ready for one cycle -> one pop, one new request at 0x10 in the next cycle.
3. Latency 3 with 3 requests in flight, redirect_pc=0x100 -> FIFO flushed and 3 responses dropped. The next delivered entry is instr_pc=0x100 carrying the memory word at 0x100.
4. Redirect in the same cycle as an rvalid and a pop -> popped entry consumed, rvalid word dropped, no stale PC ever delivered.
5. RESET asserted mid-stream with the FIFO holding 2 entries -> next cycle instr_valid=0, pc=RESET_PC, fetch restarts at 0x0.
6. (MISALIGN_TRAP_EN) Redirect to 0x102 -> fetch_fault=1 and imem_req held 0. Redirect to 0x200 -> fault clears and the next imem_addr is 0x200. Without the macro, 0x102 fetches 0x100.

Source files
------------

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and decode handshake.
// The master modport is the fetch unit; the slave modport is memory, decode and redirect logic.
interface rv32i_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited in-order imem requests, PC-tagged response FIFO, redirect flush.
// Optional MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_fault.

module rv32i_fetch_unit_chk #(
    parameter int          DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input logic          CLK,
    input logic          RESET,
    input logic          push_s,
    input logic          pop_s,
    input logic          halted_s,
    input logic [CW-1:0] count_r,
    input logic [CW-1:0] inflight_r,
    input logic [CW-1:0] discard_r,
    input logic [31:0]   fault_addr_s
);
    a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
        (push_s && !pop_s) |-> (count_r < CW'(DEPTH)));
    a_inflight_bound: assert property (@(posedge CLK) disable iff (RESET)
        inflight_r <= CW'(DEPTH));
    a_discard_bound: assert property (@(posedge CLK) disable iff (RESET)
        discard_r <= inflight_r);
    a_fault_addr_misaligned: assert property (@(posedge CLK) disable iff (RESET)
        halted_s |-> (fault_addr_s != {fault_addr_s[31:2], 2'b00}));
endmodule

module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    localparam int unsigned CW      = $clog2(DEPTH) + 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    rv32i_fetch_unit_if.master bus
);
    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] discard_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] tag_wr_ptr_r;
    logic [AW-1:0] tag_rd_ptr_r;
    logic [31:0]   data_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   tag_mem_r  [DEPTH];

    logic [CW:0]   occupancy_s;
    logic [CW-1:0] inflight_next_s;
    logic          issue_s;
    logic          pop_s;
    logic          push_s;
    logic          discard_s;
    logic          misalign_s;
    logic          halted_s;
    logic [31:0]   target_s;
    logic [31:0]   fault_addr_s;

    assign target_s = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef MISALIGN_TRAP_EN
    logic        halted_r;
    logic [31:0] fault_addr_r;

    assign misalign_s   = (bus.redirect_pc[1:0] != 2'b00);
    assign halted_s     = halted_r;
    assign fault_addr_s = fault_addr_r;

    // Trap state: set by a misaligned redirect, cleared by reset or an aligned redirect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            halted_r     <= 1'b0;
            fault_addr_r <= 32'h0000_0000;
        end else if (bus.redirect_valid) begin
            halted_r <= misalign_s;
            if (misalign_s) begin
                fault_addr_r <= bus.redirect_pc;
            end
        end
    end

    assign bus.fetch_fault = halted_r;
`else
    assign misalign_s      = 1'b0;
    assign halted_s        = 1'b0;
    assign fault_addr_s    = 32'h0000_0000;
    assign bus.fetch_fault = 1'b0;
`endif

    // Per-cycle issue, response and handshake decisions.
    always_comb begin
        occupancy_s     = {1'b0, inflight_r} + {1'b0, count_r};
        issue_s         = !RESET && !bus.redirect_valid && !halted_s &&
                          (occupancy_s < (CW+1)'(DEPTH));
        pop_s           = (count_r != '0) && bus.instr_ready;
        discard_s       = (discard_r != '0);
        push_s          = bus.imem_rvalid && !discard_s && !bus.redirect_valid;
        inflight_next_s = inflight_r + CW'(issue_s) - CW'(bus.imem_rvalid);
    end

    // Program counter, credit/occupancy/discard counters and queue pointers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_r         <= RESET_PC;
            count_r      <= '0;
            inflight_r   <= '0;
            discard_r    <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            tag_wr_ptr_r <= '0;
            tag_rd_ptr_r <= '0;
        end else begin
            inflight_r <= inflight_next_s;
            // Every response consumes its tag, including discarded ones, so tags stay aligned.
            if (bus.imem_rvalid) begin
                tag_rd_ptr_r <= tag_rd_ptr_r + AW'(1'b1);
            end
            if (issue_s) begin
                pc_r         <= pc_r + 32'd4;
                tag_wr_ptr_r <= tag_wr_ptr_r + AW'(1'b1);
            end
            if (bus.redirect_valid) begin
                pc_r      <= target_s;
                count_r   <= '0;
                wr_ptr_r  <= '0;
                rd_ptr_r  <= '0;
                discard_r <= inflight_next_s;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
                if (bus.imem_rvalid && discard_s) begin
                    discard_r <= discard_r - CW'(1'b1);
                end
            end
        end
    end

    // Issue-time PC tags and the response FIFO payload (word plus its tag).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
                tag_mem_r[i]  <= 32'h0000_0000;
            end
        end else begin
            if (issue_s) begin
                tag_mem_r[tag_wr_ptr_r] <= pc_r;
            end
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= bus.imem_rdata;
                pc_mem_r[wr_ptr_r]   <= tag_mem_r[tag_rd_ptr_r];
            end
        end
    end

    assign bus.imem_req    = issue_s;
    assign bus.imem_addr   = pc_r;
    assign bus.instr_valid = (count_r != '0);
    assign bus.instr       = data_mem_r[rd_ptr_r];
    assign bus.instr_pc    = pc_mem_r[rd_ptr_r];

    rv32i_fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .CLK          (CLK),
        .RESET        (RESET),
        .push_s       (push_s),
        .pop_s        (pop_s),
        .halted_s     (halted_s),
        .count_r      (count_r),
        .inflight_r   (inflight_r),
        .discard_r    (discard_r),
        .fault_addr_s (fault_addr_s)
    );
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit: a latency-configurable memory model plus an
// expected-fetch queue filled at request time and drained on each decode handshake.
module tb_rv32i_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RESET;

    rv32i_fetch_unit_if bus();

    rv32i_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } pend_t;

    exp_t        sb_q[$];
    pend_t       pend_q[$];
    exp_t        mon_e;
    pend_t       mon_p;
    pend_t       mem_p;
    logic        mem_rst;

    int          vectors = 0;
    int          miscompares = 0;
    int          ncyc = 0;
    int          lat = 1;
    int          req_cnt = 0;
    int          first_valid_cyc = -1;
    int          rel_cyc = 0;
    int          req_cyc [3];
    logic [31:0] req_addr [3];
    logic [31:0] first_valid_pc = 32'h0;
    logic [31:0] exp_req_pc = RESET_PC;
    logic        halted_m = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus.instr_valid && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    // Monitor: check requests and deliveries, push expectations at request time.
    always @(negedge CLK) begin
        if (RESET) begin
            sb_q.delete();
            exp_req_pc      = RESET_PC;
            halted_m        = 1'b0;
            req_cnt         = 0;
            first_valid_cyc = -1;
        end else begin
            if (bus.instr_valid && bus.instr_ready) begin
                chk("pop_expected", {31'b0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("instr_pc", bus.instr_pc, mon_e.pc);
                    chk("instr", bus.instr, mon_e.word);
                end
            end
            if (bus.instr_valid && first_valid_cyc < 0) begin
                first_valid_cyc = ncyc;
                first_valid_pc  = bus.instr_pc;
            end
            if (halted_m) begin
                chk("req_while_halted", {31'b0, bus.imem_req}, 32'd0);
            end
            if (bus.redirect_valid) begin
                chk("req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
                sb_q.delete();
                exp_req_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef MISALIGN_TRAP_EN
                halted_m = (bus.redirect_pc[1:0] != 2'b00);
`endif
            end else if (bus.imem_req) begin
                chk("imem_addr", bus.imem_addr, exp_req_pc);
                mon_e.pc   = exp_req_pc;
                mon_e.word = mem_word(exp_req_pc);
                sb_q.push_back(mon_e);
                mon_p.addr = bus.imem_addr;
                mon_p.due  = ncyc + lat;
                pend_q.push_back(mon_p);
                if (req_cnt < 3) begin
                    req_cyc[req_cnt]  = ncyc;
                    req_addr[req_cnt] = bus.imem_addr;
                end
                req_cnt++;
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        ncyc++;
    end

    // Memory model: in-order responses, 'lat' cycles after the request; shares RESET.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge CLK);
            mem_rst = RESET;
            #1;
            if (mem_rst) begin
                pend_q.delete();
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0;
            end else if (pend_q.size() != 0 && pend_q[0].due <= ncyc) begin
                mem_p           = pend_q.pop_front();
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_p.addr);
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        // Reset state
        tick(2);
        @(negedge CLK);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_imem_req",    {31'b0, bus.imem_req},    32'd0);
        chk("rst_fetch_fault", {31'b0, bus.fetch_fault}, 32'd0);
        chk("rst_instr",       bus.instr,                32'h0);
        chk("rst_instr_pc",    bus.instr_pc,             32'h0);

        // 1: latency 1, ready high
        lat = 1;
        bus.instr_ready = 1'b1;
        apply_reset();
        rel_cyc = ncyc;
        tick(6);
        chk("t1_req0_cyc",  32'(req_cyc[0]), 32'(rel_cyc));
        chk("t1_req1_cyc",  32'(req_cyc[1]), 32'(rel_cyc + 1));
        chk("t1_req2_cyc",  32'(req_cyc[2]), 32'(rel_cyc + 2));
        chk("t1_req0_addr", req_addr[0], 32'h0);
        chk("t1_req1_addr", req_addr[1], 32'h4);
        chk("t1_req2_addr", req_addr[2], 32'h8);
        chk("t1_first_valid_cyc", 32'(first_valid_cyc), 32'(rel_cyc + 2));
        chk("t1_first_valid_pc",  first_valid_pc, 32'h0);

        // 2: credit stall with ready low, single pop frees one credit
        bus.instr_ready = 1'b0;
        apply_reset();
        tick(10);
        @(negedge CLK);
        chk("t2_req_count", 32'(req_cnt), 32'd4);
        chk("t2_req_stalled", {31'b0, bus.imem_req}, 32'd0);
        @(posedge CLK); #1;
        bus.instr_ready = 1'b1;
        @(negedge CLK);
        chk("t2_req_in_pop_cycle", {31'b0, bus.imem_req}, 32'd0);
        @(posedge CLK); #1;
        bus.instr_ready = 1'b0;
        @(negedge CLK);
        chk("t2_reissue_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("t2_reissue_addr", bus.imem_addr, 32'h10);
        tick(3);
        @(negedge CLK);
        chk("t2_req_count_after", 32'(req_cnt), 32'd5);
        @(posedge CLK); #1;
        bus.instr_ready = 1'b1;
        tick(8);

        // 3: latency 3, redirect with 3 requests in flight
        lat = 3;
        apply_reset();
        tick(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick(1);
        bus.redirect_valid = 1'b0;
        wait_valid("t3_wait_valid", 20);
        chk("t3_pc",   bus.instr_pc, 32'h100);
        chk("t3_word", bus.instr,    mem_word(32'h100));
        tick(6);

        // 4: redirect coinciding with rvalid and a pop
        lat = 1;
        apply_reset();
        tick(6);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        @(negedge CLK);
        chk("t4_pop_at_redirect", {31'b0, bus.instr_valid}, 32'd1);
        @(posedge CLK); #1;
        bus.redirect_valid = 1'b0;
        wait_valid("t4_wait_valid", 20);
        chk("t4_pc",   bus.instr_pc, 32'h200);
        chk("t4_word", bus.instr,    mem_word(32'h200));
        tick(6);

        // 5: reset mid-stream with two entries buffered
        bus.instr_ready = 1'b0;
        apply_reset();
        tick(3);
        @(negedge CLK);
        chk("t5_buffered_valid", {31'b0, bus.instr_valid}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("t5_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("t5_instr",       bus.instr,    32'h0);
        chk("t5_instr_pc",    bus.instr_pc, 32'h0);
        chk("t5_req",         {31'b0, bus.imem_req}, 32'd1);
        chk("t5_addr",        bus.imem_addr, RESET_PC);
        @(posedge CLK); #1;
        bus.instr_ready = 1'b1;
        tick(8);

        // 6: misaligned redirect
        lat = 2;
        apply_reset();
        tick(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick(1);
        bus.redirect_valid = 1'b0;
        @(negedge CLK);
`ifdef MISALIGN_TRAP_EN
        chk("t6_fault_set",   {31'b0, bus.fetch_fault}, 32'd1);
        chk("t6_req_held",    {31'b0, bus.imem_req},    32'd0);
        tick(3);
        @(negedge CLK);
        chk("t6_fault_hold",  {31'b0, bus.fetch_fault}, 32'd1);
        chk("t6_req_held2",   {31'b0, bus.imem_req},    32'd0);
        chk("t6_no_valid",    {31'b0, bus.instr_valid}, 32'd0);
        @(posedge CLK); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        @(posedge CLK); #1;
        bus.redirect_valid = 1'b0;
        @(negedge CLK);
        chk("t6_fault_clear", {31'b0, bus.fetch_fault}, 32'd0);
        chk("t6_resume_req",  {31'b0, bus.imem_req},    32'd1);
        chk("t6_resume_addr", bus.imem_addr, 32'h200);
        wait_valid("t6_wait_valid", 20);
        chk("t6_pc",   bus.instr_pc, 32'h200);
        chk("t6_word", bus.instr,    mem_word(32'h200));
`else
        chk("t6_no_fault",  {31'b0, bus.fetch_fault}, 32'd0);
        chk("t6_req",       {31'b0, bus.imem_req},    32'd1);
        chk("t6_addr",      bus.imem_addr, 32'h100);
        wait_valid("t6_wait_valid", 20);
        chk("t6_pc",   bus.instr_pc, 32'h100);
        chk("t6_word", bus.instr,    mem_word(32'h100));
`endif
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
